// File: rtl/pipeline_ctrl_if.sv
// Pipeline control bundle: hazard/status inputs from the datapath and the
// per-stage latch controls driven back by pipeline_ctrl.
// master = the controller, slave = the datapath it steers.
interface pipeline_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic             ihit;
  logic             dhit;
  logic             mem_dREN;
  logic             mem_dWEN;
  logic             ex_dREN;
  logic [4:0]       ex_regDst;
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_use_rt;
  logic             ex_pcsrc;
  logic             id_halt;
  logic             pc_en;
  logic             ifid_en;
  logic             ifid_flush;
  logic             idex_en;
  logic             idex_flush;
  logic             exmem_en;
  logic             exmem_flush;
  logic             memwb_en;
  logic             halt;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    input  ihit, dhit, mem_dREN, mem_dWEN, ex_dREN, ex_regDst, id_rs, id_rt, id_use_rt,
           ex_pcsrc, id_halt,
    output pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush, memwb_en,
           halt, stall_cnt, flush_cnt
  );

  modport slave (
    output ihit, dhit, mem_dREN, mem_dWEN, ex_dREN, ex_regDst, id_rs, id_rt, id_use_rt,
           ex_pcsrc, id_halt,
    input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush, memwb_en,
           halt, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline.
// Handles fetch/data-memory waits, load-use bubbles, EX-resolved branches and
// the halt drain. Optional perf counters: define PIPE_PERF_CNT_EN.
module pipeline_ctrl #(
  parameter int unsigned DRAIN_CYC = 3,
  parameter int unsigned CNT_W     = 32
) (
  input logic             CLK,
  input logic             RST,
  pipeline_ctrl_if.master bus
);
  localparam int unsigned DrainW = (DRAIN_CYC < 2) ? 1 : $clog2(DRAIN_CYC + 1);

  typedef enum logic [1:0] {StRun, StDwait, StDrain, StHalted} state_e;

  state_e              state_q, state_d;
  logic [DrainW-1:0]   drain_q, drain_d;
  logic                memwait, loaduse;
  logic                pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
  logic                exmem_en, exmem_flush, memwb_en, halt;

  assign memwait = (bus.mem_dREN | bus.mem_dWEN) & ~bus.dhit;
  assign loaduse = bus.ex_dREN & (bus.ex_regDst != 5'd0) &
                   ((bus.ex_regDst == bus.id_rs) | (bus.id_use_rt & (bus.ex_regDst == bus.id_rt)));

  // State and drain counter registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= StRun;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
    end
  end

  // Next state and latch controls; reset forces all latches to bubble
  always_comb begin
    state_d     = state_q;
    drain_d     = drain_q;
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    ifid_flush  = 1'b0;
    idex_en     = 1'b0;
    idex_flush  = 1'b0;
    exmem_en    = 1'b0;
    exmem_flush = 1'b0;
    memwb_en    = 1'b0;
    halt        = 1'b0;
    unique case (state_q)
      // DWAIT only differs from RUN in that it is entered on a wait; once
      // dhit arrives the same priority rules apply, so a held branch is kept.
      StRun, StDwait: begin
        if (memwait) begin
          state_d = StDwait;
        end else begin
          state_d  = StRun;
          idex_en  = 1'b1;
          exmem_en = 1'b1;
          memwb_en = 1'b1;
          if (bus.ex_pcsrc) begin
            pc_en      = 1'b1;
            ifid_en    = 1'b1;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
          end else if (loaduse || !bus.ihit) begin
            idex_flush = 1'b1;
          end else if (bus.id_halt) begin
            ifid_en    = 1'b1;
            ifid_flush = 1'b1;
            drain_d    = DrainW'(DRAIN_CYC);
            state_d    = StDrain;
          end else begin
            pc_en   = 1'b1;
            ifid_en = 1'b1;
          end
        end
      end
      // Branch resolution is ignored: the halt is already past any branch.
      StDrain: begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        if (!memwait) begin
          ifid_en  = 1'b1;
          idex_en  = 1'b1;
          exmem_en = 1'b1;
          memwb_en = 1'b1;
          if (drain_q <= DrainW'(1)) begin
            drain_d = '0;
            state_d = StHalted;
          end else begin
            drain_d = drain_q - DrainW'(1);
          end
        end
      end
      StHalted: begin
        halt = 1'b1;
      end
      default: begin
        state_d = StRun;
      end
    endcase
    if (RST) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_en    = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      halt        = 1'b0;
    end
  end

  assign bus.pc_en       = pc_en;
  assign bus.ifid_en     = ifid_en;
  assign bus.ifid_flush  = ifid_flush;
  assign bus.idex_en     = idex_en;
  assign bus.idex_flush  = idex_flush;
  assign bus.exmem_en    = exmem_en;
  assign bus.exmem_flush = exmem_flush;
  assign bus.memwb_en    = memwb_en;
  assign bus.halt        = halt;

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q, flush_q;
  logic             run_like;

  assign run_like = (state_q == StRun) || (state_q == StDwait);

  // Saturating perf counters; they freeze naturally once HALTED
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (run_like && !pc_en && (stall_q != '1)) stall_q <= stall_q + CNT_W'(1);
      if (run_like && !memwait && bus.ex_pcsrc && (flush_q != '1)) flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign bus.stall_cnt = stall_q;
  assign bus.flush_cnt = flush_q;
`else
  assign bus.stall_cnt = {CNT_W{1'b0}};
  assign bus.flush_cnt = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: a rule-level model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_pipeline_ctrl;
  localparam int unsigned DRAIN_CYC = 3;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  pipeline_ctrl_if #(.CNT_W(32)) bus ();

  pipeline_ctrl #(.DRAIN_CYC(DRAIN_CYC), .CNT_W(32)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  // Model: cycles of drain left (0 = not draining), halted flag, perf counts
  int          m_drain  = 0;
  bit          m_halted = 0;
  int unsigned m_stall  = 0;
  int unsigned m_flush  = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
    end
  endtask

  // Output bits: pc_en ifid_en ifid_flush idex_en idex_flush exmem_en exmem_flush memwb_en halt
  always @(negedge CLK) begin
    logic [8:0]  e, m, got;
    logic [31:0] exp_s, exp_f;
    bit          mw, lu, acted, stall;
    if (RST) begin
      m_drain  = 0;
      m_halted = 0;
      m_stall  = 0;
      m_flush  = 0;
    end
    mw = (bus.mem_dREN || bus.mem_dWEN) && !bus.dhit;
    lu = bus.ex_dREN && (bus.ex_regDst != 0) &&
         ((bus.ex_regDst == bus.id_rs) || (bus.id_use_rt && (bus.ex_regDst == bus.id_rt)));
    m = '1;
    acted = 0;
    stall = 0;
    if (RST) e = 9'b0_0_1_0_1_0_1_0_0;
    else if (m_halted) e = 9'b0_0_0_0_0_0_0_0_1;
    else if (m_drain > 0) begin
      m[7] = 1'b0;
      m[5] = 1'b0;
      e = mw ? 9'b0_0_1_0_1_0_0_0_0 : 9'b0_0_1_0_1_1_0_1_0;
    end else if (mw) begin
      e = 9'b0;
      stall = 1;
    end else if (bus.ex_pcsrc) begin
      e = 9'b1_1_1_1_1_1_0_1_0;
      acted = 1;
    end else if (lu) begin
      e = 9'b0_0_0_1_1_1_0_1_0;
      m[5] = 1'b0;
      stall = 1;
    end else if (!bus.ihit) begin
      e = 9'b0_0_0_1_1_1_0_1_0;
      stall = 1;
    end else if (bus.id_halt) begin
      e = 9'b0_1_1_1_0_1_0_1_0;
      stall = 1;
    end else begin
      e = 9'b1_1_0_1_0_1_0_1_0;
    end
    got = {bus.pc_en, bus.ifid_en, bus.ifid_flush, bus.idex_en, bus.idex_flush,
           bus.exmem_en, bus.exmem_flush, bus.memwb_en, bus.halt};
    chk("ctrl_outputs", {23'd0, got & m}, {23'd0, e & m});
`ifdef PIPE_PERF_CNT_EN
    exp_s = m_stall;
    exp_f = m_flush;
`else
    exp_s = 0;
    exp_f = 0;
`endif
    chk("stall_cnt", bus.stall_cnt, exp_s);
    chk("flush_cnt", bus.flush_cnt, exp_f);
    if (!RST && !m_halted) begin
      if (m_drain > 0) begin
        if (!mw) begin
          m_drain--;
          if (m_drain == 0) m_halted = 1;
        end
      end else begin
        if (!mw && !bus.ex_pcsrc && !lu && bus.ihit && bus.id_halt) m_drain = DRAIN_CYC;
        if (stall && m_stall != 32'hffff_ffff) m_stall++;
        if (acted && m_flush != 32'hffff_ffff) m_flush++;
      end
    end
  end

  task automatic idle();
    bus.ihit = 1; bus.dhit = 0; bus.mem_dREN = 0; bus.mem_dWEN = 0; bus.ex_dREN = 0;
    bus.ex_regDst = 0; bus.id_rs = 0; bus.id_rt = 0; bus.id_use_rt = 0;
    bus.ex_pcsrc = 0; bus.id_halt = 0;
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    idle();
    // Reset held two cycles
    @(negedge CLK);
    chk("rst_pc_en", bus.pc_en, 0);
    chk("rst_exmem_flush", bus.exmem_flush, 1);
    tick(2);
    RST = 0;
    @(negedge CLK);
    chk("idle_pc_en", bus.pc_en, 1);
    chk("idle_ifid_flush", bus.ifid_flush, 0);
    tick(3);
    // Load-use on rs
    bus.ex_dREN = 1; bus.ex_regDst = 8; bus.id_rs = 8;
    @(negedge CLK);
    chk("lu_pc_en", bus.pc_en, 0);
    chk("lu_idex_flush", bus.idex_flush, 1);
    tick();
    idle();
    @(negedge CLK);
    chk("after_lu_pc_en", bus.pc_en, 1);
    tick();
    // Load into r0 never stalls
    bus.ex_dREN = 1; bus.ex_regDst = 0; bus.id_rs = 0;
    @(negedge CLK);
    chk("lu_r0_pc_en", bus.pc_en, 1);
    tick();
    // rt path: stall only when rt is actually read
    bus.ex_dREN = 1; bus.ex_regDst = 9; bus.id_rs = 3; bus.id_rt = 9; bus.id_use_rt = 1;
    tick();
    bus.id_use_rt = 0;
    tick();
    idle();
    // Branch held across a data wait
    bus.ex_pcsrc = 1; bus.mem_dREN = 1; bus.dhit = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("dwait_pc_en", bus.pc_en, 0);
      tick();
    end
    bus.dhit = 1;
    @(negedge CLK);
    chk("dhit_br_pc_en", bus.pc_en, 1);
    chk("dhit_br_ifid_flush", bus.ifid_flush, 1);
    tick();
    idle();
    // Branch beats load-use
    bus.ex_pcsrc = 1; bus.ex_dREN = 1; bus.ex_regDst = 5; bus.id_rs = 5;
    @(negedge CLK);
    chk("prio_pc_en", bus.pc_en, 1);
    chk("prio_idex_flush", bus.idex_flush, 1);
    tick();
    idle();
    // Reset mid-stall, then perf scenario from clean counters
    bus.ihit = 0;
    tick();
    RST = 1;
    @(negedge CLK);
    chk("rst_stall_ifid_flush", bus.ifid_flush, 1);
    tick();
    RST = 0;
    idle();
    tick();
    bus.ihit = 0;
    tick(4);
    bus.ihit = 1; bus.ex_pcsrc = 1;
    tick(2);
    idle();
    @(negedge CLK);
`ifdef PIPE_PERF_CNT_EN
    chk("perf_stall", bus.stall_cnt, 4);
    chk("perf_flush", bus.flush_cnt, 2);
`else
    chk("perf_stall_off", bus.stall_cnt, 0);
    chk("perf_flush_off", bus.flush_cnt, 0);
`endif
    tick();
    // Halt drain with a store waiting two cycles; branch in drain is ignored
    bus.id_halt = 1;
    @(negedge CLK);
    chk("halt_issue_pc_en", bus.pc_en, 0);
    chk("halt_issue_ifid_flush", bus.ifid_flush, 1);
    tick();
    n = 0;
    while (n < 20) begin
      bus.id_halt = 0; bus.dhit = 0;
      bus.mem_dWEN = (n < 2); bus.ex_pcsrc = (n == 2);
      @(negedge CLK);
      if (bus.halt) break;
      n++;
      tick();
    end
    chk("halt_latency", n, 5);
    tick();
    idle();
    bus.ex_pcsrc = 1;
    @(negedge CLK);
    chk("halted_pc_en", bus.pc_en, 0);
    chk("halted_halt", bus.halt, 1);
    tick(2);
    // Reset mid-drain
    idle();
    RST = 1;
    tick();
    RST = 0;
    tick();
    bus.id_halt = 1;
    tick();
    bus.id_halt = 0;
    tick();
    RST = 1;
    @(negedge CLK);
    chk("rst_drain_pc_en", bus.pc_en, 0);
    chk("rst_drain_halt", bus.halt, 0);
    tick();
    RST = 0;
    @(negedge CLK);
    chk("post_rst_pc_en", bus.pc_en, 1);
    tick(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Hazard and sequencing controller for the 5-stage pipeline.
- Issues per-cycle enable/flush to PC, IF/ID, ID/EX (execute latch), EX/MEM and MEM/WB latches.
- Resolves instruction-fetch waits, data-memory waits, load-use hazards, taken branches/jumps resolved in EX, and halt drain.
- Sits beside the datapath; consumes decode/execute status, drives the latch control inputs (flush, ihit-qualified enable) of every stage.

Parameters:
DRAIN_CYC, 3, advancing cycles after halt leaves ID until the pipeline is empty
CNT_W, 32, width of performance counters (optional feature only)

Ports:
CLK  in  1  clock
RST  in  1  asynchronous active-high reset
ihit  in  1  instruction fetch complete this cycle
dhit  in  1  data access complete this cycle
mem_dREN  in  1  MEM-stage load
mem_dWEN  in  1  MEM-stage store
ex_dREN  in  1  EX-stage instruction is a load
ex_regDst  in  5  EX-stage destination register
id_rs  in  5  ID-stage source rs
id_rt  in  5  ID-stage source rt
id_use_rt  in  1  ID instruction reads rt
ex_pcsrc  in  1  EX resolved taken branch or jump (from equal/branch logic)
id_halt  in  1  ID instruction is HALT
pc_en  out  1  PC update enable
ifid_en  out  1  IF/ID enable
ifid_flush  out  1  IF/ID clear to bubble
idex_en  out  1  ID/EX enable
idex_flush  out  1  ID/EX clear to bubble
exmem_en  out  1  EX/MEM enable
exmem_flush  out  1  EX/MEM clear
memwb_en  out  1  MEM/WB enable
halt  out  1  pipeline halted
stall_cnt  out  CNT_W  stall cycles (optional)
flush_cnt  out  CNT_W  flush events (optional)

Behaviour:
- Clock and reset: one clock CLK; reset RST asynchronous, active-high.
- While RST is high:
  - all *_en = 0; ifid_flush = idex_flush = exmem_flush = 1; halt = 0.
  - state = RUN, drain counter = 0, perf counters = 0.
- Outputs are combinational from state plus current inputs; state updates on the rising CLK edge.
- States: RUN, DWAIT, DRAIN, HALTED.
- memwait = (mem_dREN | mem_dWEN) & ~dhit.
- loaduse = ex_dREN & (ex_regDst != 0) & ((ex_regDst == id_rs) | (id_use_rt & ex_regDst == id_rt)).
- RUN, priority top to bottom:
  1. memwait: all enables 0, no flushes; next state DWAIT.
  2. ex_pcsrc: all enables 1; ifid_flush = idex_flush = 1 (two bubbles); PC loads target.
  3. loaduse: pc_en = ifid_en = 0; idex_flush = 1; EX/MEM and MEM/WB advance. Exactly one bubble.
  4. ~ihit: pc_en = ifid_en = 0; idex_flush = 1; later stages advance.
  5. id_halt (ID advancing): all enables 1; pc_en = 0; ifid_flush = 1; drain counter = DRAIN_CYC; next state DRAIN.
  6. Otherwise all enables 1, no flushes.
- DWAIT: all enables 0 until dhit.
  - Then behave as RUN for that cycle (rules 2–6 evaluated) and return to RUN.
  - A pending ex_pcsrc is therefore never lost.
- DRAIN:
  - pc_en = 0, ifid_flush = 1, idex_flush = 1.
  - exmem_en / memwb_en follow memwait (0 while waiting).
  - Counter decrements on each non-waiting cycle; reaching 0 goes to HALTED.
  - ex_pcsrc is ignored in DRAIN (halt is already past the branch).
- HALTED: all enables 0, halt = 1; exit only via RST.
- RST asserted mid-stall or mid-drain returns immediately to reset outputs.

Optional Feature:
- Macro PIPE_PERF_CNT_EN.
- Defined:
  - stall_cnt increments on every RUN/DWAIT cycle where pc_en = 0.
  - flush_cnt increments on each cycle with ex_pcsrc acted upon.
  - Both saturate at all-ones and freeze in HALTED.
- Undefined: stall_cnt and flush_cnt ports are tied to 0 and no counter registers exist.

Test Plan:
- Reset/idle: RST high 2 cycles, then ihit = 1 with no hazards → during RST flushes = 1 and enables = 0; afterwards all enables = 1 and flushes = 0 every cycle.
- Load-use: ex_dREN = 1, ex_regDst = 8, id_rs = 8 → one cycle with pc_en = 0, ifid_en = 0, idex_flush = 1; next cycle all enables = 1. With ex_regDst = 0, no stall.
- Branch over memwait: ex_pcsrc = 1 with mem_dREN = 1, dhit = 0 for 3 cycles → enables 0 for 3 cycles (state DWAIT); on the dhit cycle ifid_flush = idex_flush = 1 and pc_en = 1.
- Priority: ex_pcsrc = 1 and loaduse = 1 same cycle → flush behaviour only, pc_en = 1.
- Halt drain: id_halt = 1, then a store with dhit delayed 2 cycles during DRAIN → halt asserts exactly 3 advancing cycles later (5 clocks total); all enables stay 0 thereafter.
- PIPE_PERF_CNT_EN: 4 ~ihit cycles plus 2 taken branches → stall_cnt = 4, flush_cnt = 2; without the macro both read 0.
